// File: rtl/ex_pkg.sv
// Shared types for the execute commit stage: condition codes, flag bit positions, buffered entry.
package ex_pkg;

  localparam int ENT_DATA_W = 32;
  localparam int ENT_RD_W   = 4;

  // Bit positions inside the {N,Z,C,V} flags register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_LT = 4'd3,
    COND_GE = 4'd4,
    COND_GT = 4'd5,
    COND_LE = 4'd6,
    COND_CS = 4'd7,
    COND_CC = 4'd8
  } cond_e;

  typedef struct packed {
    logic [ENT_DATA_W-1:0] result;
    logic [ENT_RD_W-1:0]   rd;
    logic                  wr_en;
    logic                  is_store;
    logic [ENT_DATA_W-1:0] store_data;
  } ex_entry_t;

endpackage

// File: rtl/ex_skid_buf.sv
// Two-entry skid buffer (head + skid register), 1-cycle latency, strict FIFO order.
// push_ready is ~skid_full straight from a flop, so it never depends on pop_ready.
module ex_skid_buf
  import ex_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push_valid,
  input  ex_entry_t push_data,
  output logic      push_ready,
  output logic      pop_valid,
  input  logic      pop_ready,
  output ex_entry_t pop_data
);

  logic      main_vld;
  logic      skid_vld;
  ex_entry_t main_q;
  ex_entry_t skid_q;
  logic      push_ok;
  logic      head_free;

  assign push_ok   = push_valid & ~skid_vld;
  assign head_free = ~main_vld | pop_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (head_free) begin
      // The skid entry is older than anything arriving, so it refills the head first
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (push_ok) begin
        main_q   <= push_data;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (push_ok) begin
      skid_q   <= push_data;
      skid_vld <= 1'b1;
    end
  end

  assign push_ready = ~skid_vld;
  assign pop_valid  = main_vld;
  assign pop_data   = main_q;

endmodule

// File: rtl/ex_commit_stage.sv
// Post-ALU commit stage: owns the flags register, drops condition-failed instructions,
// and forwards survivors through a 2-entry skid buffer (1-cycle latency, registered in_ready).
module ex_commit_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = ENT_DATA_W,
  parameter int RD_W   = ENT_RD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  input  logic              alu_c,
  input  logic [3:0]        cond,
  input  logic              set_flags,
  input  logic [RD_W-1:0]   rd_addr,
  input  logic              wr_en,
  input  logic              is_store,
  input  logic [DATA_W-1:0] store_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic              out_is_store,
  output logic [DATA_W-1:0] out_store_data,
  output logic [3:0]        flags_q
);

  logic      cond_pass;
  logic      push;
  logic      f_n, f_z, f_c, f_v;
  ex_entry_t in_ent;
  ex_entry_t out_ent;

  assign f_n = flags_q[FLAG_N];
  assign f_z = flags_q[FLAG_Z];
  assign f_c = flags_q[FLAG_C];
  assign f_v = flags_q[FLAG_V];

  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(cond))
      COND_AL: cond_pass = 1'b1;
      COND_EQ: cond_pass = f_z;
      COND_NE: cond_pass = ~f_z;
      COND_LT: cond_pass = f_n ^ f_v;
      COND_GE: cond_pass = ~(f_n ^ f_v);
      COND_GT: cond_pass = ~f_z & ~(f_n ^ f_v);
      COND_LE: cond_pass = f_z | (f_n ^ f_v);
      COND_CS: cond_pass = f_c;
      COND_CC: cond_pass = ~f_c;
      default: cond_pass = 1'b0;
    endcase
  end

  // Failed instructions are still consumed (accepted) but never enqueued
  assign push = in_valid & in_ready & ~flush & cond_pass;

  always_ff @(posedge clk) begin
    if (!rst_n)
      flags_q <= 4'b0000;
    else if (push && set_flags)
      flags_q <= {alu_n, alu_z, alu_c, alu_v};
  end

  always_comb begin
    in_ent            = '0;
    in_ent.result     = alu_result;
    in_ent.rd         = rd_addr;
    in_ent.wr_en      = wr_en;
    in_ent.is_store   = is_store;
    in_ent.store_data = store_data;
  end

  ex_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push),
    .push_data  (in_ent),
    .push_ready (in_ready),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (out_ent)
  );

  assign out_result     = out_ent.result;
  assign out_rd         = out_ent.rd;
  assign out_wr_en      = out_ent.wr_en;
  assign out_is_store   = out_ent.is_store;
  assign out_store_data = out_ent.store_data;

endmodule

// File: tb/tb_ex_commit_stage.sv
// Directed bench for ex_commit_stage with a queue scoreboard of expected output entries.
module tb_ex_commit_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic        alu_z, alu_n, alu_v, alu_c;
  logic [3:0]  cond;
  logic        set_flags;
  logic [3:0]  rd_addr;
  logic        wr_en;
  logic        is_store;
  logic [31:0] store_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic        out_is_store;
  logic [31:0] out_store_data;
  logic [3:0]  flags_q;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [3:0] mflags = 4'b0000;
  ex_entry_t sb[$];

  always #5 clk = ~clk;

  ex_commit_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
    .cond(cond), .set_flags(set_flags), .rd_addr(rd_addr), .wr_en(wr_en),
    .is_store(is_store), .store_data(store_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_is_store(out_is_store),
    .out_store_data(out_store_data), .flags_q(flags_q)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // flags = {N,Z,C,V}
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return n != v;
      4'd4: return n == v;
      4'd5: return !z && (n == v);
      4'd6: return z || (n != v);
      4'd7: return cc;
      4'd8: return !cc;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] r, input logic [3:0] c, input logic sf,
                       input logic [3:0] nzcv);
    in_valid   = 1'b1;
    alu_result = r;
    cond       = c;
    set_flags  = sf;
    {alu_n, alu_z, alu_c, alu_v} = nzcv;
    rd_addr    = r[3:0] ^ 4'h5;
    wr_en      = ~r[1];
    is_store   = r[0];
    store_data = ~r;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    set_flags = 1'b0;
  endtask

  // Inputs are stable here; observe at negedge, then advance to just past the next posedge
  task automatic step();
    ex_entry_t e, h;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      mflags = 4'b0000;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          check("unexpected_output", {32'h0, out_result}, 64'hDEAD_0000_0000_0000);
        end else begin
          h = sb.pop_front();
          check("out_result", {32'h0, out_result}, {32'h0, h.result});
          check("out_rd", {60'h0, out_rd}, {60'h0, h.rd});
          check("out_wr_en", {63'h0, out_wr_en}, {63'h0, h.wr_en});
          check("out_is_store", {63'h0, out_is_store}, {63'h0, h.is_store});
          check("out_store_data", {32'h0, out_store_data}, {32'h0, h.store_data});
        end
      end
      if (in_valid && in_ready && cond_ok(cond, mflags)) begin
        e.result = alu_result; e.rd = rd_addr; e.wr_en = wr_en;
        e.is_store = is_store; e.store_data = store_data;
        sb.push_back(e);
        if (set_flags) mflags = {alu_n, alu_z, alu_c, alu_v};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    alu_result = '0; cond = '0; rd_addr = '0; wr_en = 1'b0; is_store = 1'b0;
    store_data = '0; {alu_n, alu_z, alu_c, alu_v} = 4'b0;
    idle();
    step(); step();
    rst_n = 1'b1;
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_in_ready", {63'h0, in_ready}, 64'd1);
    check("rst_flags", {60'h0, flags_q}, 64'd0);
    check("rst_out_result", {32'h0, out_result}, 64'd0);
    check("rst_out_store_data", {32'h0, out_store_data}, 64'd0);

    // 1: single AL instruction, 1-cycle latency
    drive(32'd15, 4'd0, 1'b1, 4'b0000); step(); idle();
    check("t1_out_valid", {63'h0, out_valid}, 64'd1);
    check("t1_out_result", {32'h0, out_result}, 64'd15);
    check("t1_flags", {60'h0, flags_q}, 64'd0);
    step();
    check("t1_empty", {63'h0, out_valid}, 64'd0);

    // 2: set Z, then EQ passes and NE is dropped
    drive(32'd0, 4'd0, 1'b1, 4'b0100); step();
    check("t2_flags", {60'h0, flags_q}, 64'h4);
    drive(32'd7, 4'd1, 1'b0, 4'b0000); step();
    drive(32'd9, 4'd2, 1'b0, 4'b0000); step(); idle();
    drain("t2_drain");
    step(); step();
    check("t2_no_9", {63'h0, out_valid}, 64'd0);
    check("t2_flags_kept", {60'h0, flags_q}, 64'h4);

    // 3: backpressure fills head+skid, third input held off
    out_ready = 1'b0; p0 = pops;
    drive(32'd1, 4'd0, 1'b0, 4'b0000); step();
    check("t3_ready_after1", {63'h0, in_ready}, 64'd1);
    drive(32'd2, 4'd0, 1'b0, 4'b0000); step();
    check("t3_ready_after2", {63'h0, in_ready}, 64'd0);
    drive(32'd3, 4'd0, 1'b0, 4'b0000); step();
    check("t3_ready_held", {63'h0, in_ready}, 64'd0);
    check("t3_head_stable", {32'h0, out_result}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && in_valid; i++) begin
      if (in_ready) begin step(); idle(); end
      else step();
    end
    idle();
    drain("t3_drain");
    check("t3_pop_count", 64'(pops - p0), 64'd3);

    // 4: flush drops buffered entries and a same-cycle flag update
    out_ready = 1'b0;
    drive(32'd21, 4'd0, 1'b0, 4'b0000); step();
    drive(32'd22, 4'd0, 1'b0, 4'b0000); step();
    drive(32'd23, 4'd0, 1'b1, 4'b1000); flush = 1'b1; step();
    flush = 1'b0; idle();
    check("t4_out_valid", {63'h0, out_valid}, 64'd0);
    check("t4_flags", {60'h0, flags_q}, 64'h4);
    check("t4_in_ready", {63'h0, in_ready}, 64'd1);
    out_ready = 1'b1; step(); step();
    check("t4_nothing_out", {63'h0, out_valid}, 64'd0);

    // 5: reset mid-operation, inputs ignored during reset
    out_ready = 1'b0;
    drive(32'd31, 4'd0, 1'b0, 4'b0000); step();
    drive(32'd32, 4'd0, 1'b0, 4'b0000); step();
    check("t5_pre_flags", {60'h0, flags_q}, 64'h4);
    drive(32'd33, 4'd0, 1'b1, 4'b1010); rst_n = 1'b0; step();
    rst_n = 1'b1; idle();
    check("t5_out_valid", {63'h0, out_valid}, 64'd0);
    check("t5_flags", {60'h0, flags_q}, 64'd0);
    check("t5_in_ready", {63'h0, in_ready}, 64'd1);
    check("t5_out_result", {32'h0, out_result}, 64'd0);

    // 6: reserved condition never passes
    out_ready = 1'b1;
    drive(32'd41, 4'hF, 1'b1, 4'b0010); step(); idle();
    check("t6_out_valid", {63'h0, out_valid}, 64'd0);
    check("t6_flags", {60'h0, flags_q}, 64'd0);

    // Sweep every cond with N=1,Z=0,C=1,V=0: AL,NE,LT,LE,CS pass
    drive(32'd100, 4'd0, 1'b1, 4'b1010); step();
    check("sweep_flags", {60'h0, flags_q}, 64'hA);
    p0 = pops;
    for (int c = 0; c < 16; c++) begin
      drive(32'd200 + 32'(c), 4'(c), 1'b0, 4'b0000); step();
    end
    idle();
    drain("sweep_drain");
    check("sweep_pop_count", 64'(pops - p0), 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
